fix_tx_msg_buffer: RTL and testbench

FIX_TX_MSG_BUFFER -- requirements
Module: fix_tx_msg_buffer

---
 rtl/fix_tx_msg_buffer.sv | 187 ++++++++++++++++++
 tb/tb_fix_tx_msg_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_tx_msg_buffer.sv
// Transmit message buffer between a FIX engine and a TOE: bytes are stored speculatively and
// become visible to the read side only once their message is committed with end_i.
module fix_tx_msg_buffer #(
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned MAX_MSGS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fifo_write_i,
    input  logic [7:0]                  message_i,
    input  logic                        end_i,
    output logic                        fifo_full_o,
    output logic                        tx_valid_o,
    output logic [7:0]                  tx_data_o,
    output logic                        tx_last_o,
    input  logic                        tx_ready_i,
    output logic                        drop_o,
    output logic [$clog2(MAX_MSGS):0]   msg_count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned QW = $clog2(MAX_MSGS);

    typedef logic [AW:0]   len_t;
    typedef logic [AW-1:0] ptr_t;
    typedef logic [QW:0]   cnt_t;
    typedef logic [QW-1:0] qptr_t;

    typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

    logic [7:0] mem_q    [DEPTH];
    len_t       lq_mem_q [MAX_MSGS];

    state_e state_q, state_d;
    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   commit_ptr_q, commit_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    len_t   open_len_q, open_len_d;
    len_t   committed_q, committed_d;
    len_t   remaining_q, remaining_d;
    logic   ovf_q, ovf_d;
    qptr_t  lq_wr_q, lq_wr_d;
    qptr_t  lq_rd_q, lq_rd_d;
    cnt_t   lq_cnt_q, lq_cnt_d;
    cnt_t   msg_cnt_q, msg_cnt_d;
    logic   tx_valid_q, tx_valid_d;
    logic   tx_last_q, tx_last_d;
    logic   fifo_full_q, fifo_full_d;
    logic   drop_q, drop_d;
    logic [7:0] tx_data_q;

    logic   byte_full, wr_en, ovf_now, qfull, commit, drop, pop, xfer, last_xfer, rd_en;
    len_t   used, new_len;
    ptr_t   wr_ptr_inc, rd_addr;

    always_comb begin
        used       = open_len_q + committed_q;
        byte_full  = (used == len_t'(DEPTH));
        wr_en      = fifo_write_i & ~byte_full;
        ovf_now    = ovf_q | (fifo_write_i & byte_full);
        new_len    = open_len_q + len_t'(wr_en);
        wr_ptr_inc = wr_ptr_q + AW'(wr_en);
        // Queue occupancy counts messages until their last byte leaves, not until popped.
        qfull      = (msg_cnt_q == cnt_t'(MAX_MSGS));
        commit     = end_i & (new_len != '0) & ~ovf_now & ~qfull;
        drop       = end_i & (ovf_now | ((new_len != '0) & qfull));

        wr_ptr_d     = drop ? commit_ptr_q : wr_ptr_inc;
        commit_ptr_d = commit ? wr_ptr_inc : commit_ptr_q;
        open_len_d   = end_i ? '0 : new_len;
        ovf_d        = end_i ? 1'b0 : ovf_now;
        lq_wr_d      = commit ? lq_wr_q + QW'(1) : lq_wr_q;
        drop_d       = drop;

        xfer      = tx_valid_q & tx_ready_i;
        last_xfer = xfer & tx_last_q;
        pop       = (state_q == StLoad);

        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        lq_rd_d     = lq_rd_q;
        remaining_d = remaining_q;
        tx_valid_d  = tx_valid_q;
        tx_last_d   = tx_last_q;
        rd_en       = 1'b0;
        rd_addr     = rd_ptr_q;

        unique case (state_q)
            StIdle: begin
                if (lq_cnt_q != '0) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                remaining_d = lq_mem_q[lq_rd_q];
                lq_rd_d     = lq_rd_q + QW'(1);
                rd_en       = 1'b1;
                tx_valid_d  = 1'b1;
                tx_last_d   = (lq_mem_q[lq_rd_q] == len_t'(1));
                state_d     = StSend;
            end
            StSend: begin
                if (xfer) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    if (tx_last_q) begin
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        state_d    = StIdle;
                    end else begin
                        remaining_d = remaining_q - len_t'(1);
                        tx_last_d   = (remaining_q == len_t'(2));
                        rd_en       = 1'b1;
                        rd_addr     = rd_ptr_q + AW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        committed_d = committed_q + (commit ? new_len : '0) - len_t'(xfer);
        lq_cnt_d    = lq_cnt_q + cnt_t'(commit) - cnt_t'(pop);
        msg_cnt_d   = msg_cnt_q + cnt_t'(commit) - cnt_t'(last_xfer);
        fifo_full_d = ((open_len_d + committed_d) == len_t'(DEPTH)) |
                      (msg_cnt_d == cnt_t'(MAX_MSGS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            open_len_q   <= '0;
            committed_q  <= '0;
            remaining_q  <= '0;
            ovf_q        <= 1'b0;
            lq_wr_q      <= '0;
            lq_rd_q      <= '0;
            lq_cnt_q     <= '0;
            msg_cnt_q    <= '0;
            tx_valid_q   <= 1'b0;
            tx_last_q    <= 1'b0;
            fifo_full_q  <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            open_len_q   <= open_len_d;
            committed_q  <= committed_d;
            remaining_q  <= remaining_d;
            ovf_q        <= ovf_d;
            lq_wr_q      <= lq_wr_d;
            lq_rd_q      <= lq_rd_d;
            lq_cnt_q     <= lq_cnt_d;
            msg_cnt_q    <= msg_cnt_d;
            tx_valid_q   <= tx_valid_d;
            tx_last_q    <= tx_last_d;
            fifo_full_q  <= fifo_full_d;
            drop_q       <= drop_d;
        end
    end

    // Storage arrays carry no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= message_i;
        end
        if (commit) begin
            lq_mem_q[lq_wr_q] <= new_len;
        end
        if (rst) begin
            tx_data_q <= '0;
        end else if (rd_en) begin
            tx_data_q <= mem_q[rd_addr];
        end
    end

    assign fifo_full_o = fifo_full_q;
    assign tx_valid_o  = tx_valid_q;
    assign tx_data_o   = tx_data_q;
    assign tx_last_o   = tx_last_q;
    assign drop_o      = drop_q;
    assign msg_count_o = msg_cnt_q;

endmodule

// File: tb/tb_fix_tx_msg_buffer.sv
// Directed bench for fix_tx_msg_buffer (DEPTH=16, MAX_MSGS=8): a per-cycle vector table plus
// hand-written sequences for latency, back-pressure, overflow, queue-full and reset corners.
module tb_fix_tx_msg_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_write_i;
    logic [7:0] message_i;
    logic       end_i;
    logic       fifo_full_o;
    logic       tx_valid_o;
    logic [7:0] tx_data_o;
    logic       tx_last_o;
    logic       tx_ready_i;
    logic       drop_o;
    logic [3:0] msg_count_o;

    fix_tx_msg_buffer #(
        .DEPTH    (16),
        .MAX_MSGS (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_write_i (fifo_write_i),
        .message_i    (message_i),
        .end_i        (end_i),
        .fifo_full_o  (fifo_full_o),
        .tx_valid_o   (tx_valid_o),
        .tx_data_o    (tx_data_o),
        .tx_last_o    (tx_last_o),
        .tx_ready_i   (tx_ready_i),
        .drop_o       (drop_o),
        .msg_count_o  (msg_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       en;
        logic       rdy;
        logic       v;
        logic [7:0] td;
        logic       l;
        logic       f;
        logic       dr;
        logic [3:0] c;
    } vec_t;

    vec_t       vecs [12];
    int         n_pass  = 0;
    int         n_total = 0;
    logic       mon_en  = 1'b0;
    logic [8:0] exp_q [$];
    int         xfer_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // One clock: score a transfer (or stall) seen before the edge, then step to edge+1.
    task automatic tick();
        logic       hold;
        logic [7:0] hd;
        logic       hl;
        logic [8:0] e;
        hold = 1'b0;
        hd   = '0;
        hl   = 1'b0;
        if (mon_en && tx_valid_o) begin
            if (tx_ready_i) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected byte", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx byte/last", int'({tx_data_o, tx_last_o}), int'(e));
                end
            end else begin
                hold = 1'b1;
                hd   = tx_data_o;
                hl   = tx_last_o;
            end
        end
        @(posedge clk);
        #1;
        if (hold) chk("hold while stalled", int'({tx_data_o, tx_last_o}), int'({hd, hl}));
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        fifo_write_i = 1'b0;
        message_i    = '0;
        end_i        = 1'b0;
        tx_ready_i   = 1'b0;
        mon_en       = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic e);
        fifo_write_i = 1'b1;
        message_i    = b;
        end_i        = e;
        tick();
        fifo_write_i = 1'b0;
        end_i        = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_valid_o) && n < 300) begin
            tick();
            n++;
        end
        chk({name, " drained"}, exp_q.size(), 0);
    endtask

    initial begin
        string s;
        logic [15:0] act, exp;

        // wr d end rdy | valid data last full drop count
        vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b1, 8'h43, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h43, 1'b1, 1'b0, 1'b0, 4'd1};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h43, 1'b1, 1'b0, 1'b0, 4'd1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};

        do_reset();
        chk("reset tx_valid", int'(tx_valid_o), 0);
        chk("reset tx_data", int'(tx_data_o), 0);
        chk("reset tx_last", int'(tx_last_o), 0);
        chk("reset fifo_full", int'(fifo_full_o), 0);
        chk("reset drop", int'(drop_o), 0);
        chk("reset msg_count", int'(msg_count_o), 0);

        // Per-cycle table: 3-byte message with stalls, then a zero-length end_i.
        for (int i = 0; i < 12; i++) begin
            fifo_write_i = vecs[i].wr;
            message_i    = vecs[i].d;
            end_i        = vecs[i].en;
            tx_ready_i   = vecs[i].rdy;
            tick();
            act = {tx_valid_o, tx_valid_o ? tx_data_o : 8'h00, tx_last_o, fifo_full_o, drop_o,
                   msg_count_o};
            exp = {vecs[i].v, vecs[i].v ? vecs[i].td : 8'h00, vecs[i].l, vecs[i].f, vecs[i].dr,
                   vecs[i].c};
            chk($sformatf("vec%0d", i), int'(act), int'(exp));
        end
        fifo_write_i = 1'b0;
        end_i        = 1'b0;

        // 10-byte FIX header, ready held high, latency of exactly three cycles from end_i.
        do_reset();
        s          = "8=FIX.4.2|";
        tx_ready_i = 1'b1;
        mon_en     = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back({s[i], i == 9});
        for (int i = 0; i < 10; i++) wr_byte(s[i], i == 9);
        chk("fix count after commit", int'(msg_count_o), 1);
        chk("fix valid N+1", int'(tx_valid_o), 0);
        tick();
        chk("fix valid N+2", int'(tx_valid_o), 0);
        tick();
        chk("fix valid N+3", int'(tx_valid_o), 1);
        drain("fix");
        chk("fix count end", int'(msg_count_o), 0);

        // Back-to-back 5- and 3-byte messages with ready toggling; writes overlap reads.
        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back({8'h10 + 8'(i), i == 4});
        for (int i = 0; i < 3; i++) exp_q.push_back({8'h20 + 8'(i), i == 2});
        tx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tx_ready_i = ~tx_ready_i;
            if (i < 5) wr_byte(8'h10 + 8'(i), i == 4);
            else       wr_byte(8'h20 + 8'(i - 5), i == 7);
        end
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
            tx_ready_i = ~tx_ready_i;
            tick();
        end
        chk("two msgs drained", exp_q.size(), 0);
        chk("two msgs transfers", xfer_cnt, 18);
        chk("two msgs count", int'(msg_count_o), 0);

        // Byte-store overflow: 20 bytes into 16 entries, then a lone end_i.
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            wr_byte(8'(i), 1'b0);
            if (i == 15 || i == 16 || i == 20)
                chk($sformatf("ovf full after byte %0d", i), int'(fifo_full_o), int'(i >= 16));
        end
        end_i = 1'b1;
        tick();
        end_i = 1'b0;
        chk("ovf drop pulse", int'(drop_o), 1);
        chk("ovf count", int'(msg_count_o), 0);
        chk("ovf full cleared", int'(fifo_full_o), 0);
        tick();
        chk("ovf drop single", int'(drop_o), 0);
        for (int i = 0; i < 3; i++) tick();
        chk("ovf no output", int'(tx_valid_o), 0);

        // Length-queue full: eight one-byte messages fill it, a ninth is dropped.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr_byte(8'h60 + 8'(i), 1'b1);
            if (i == 6 || i == 7)
                chk($sformatf("qfull full after msg %0d", i + 1), int'(fifo_full_o), int'(i == 7));
        end
        chk("qfull count", int'(msg_count_o), 8);
        wr_byte(8'h99, 1'b1);
        chk("qfull ninth drop", int'(drop_o), 1);
        chk("qfull ninth count", int'(msg_count_o), 8);
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back({8'h60 + 8'(i), 1'b1});
        tx_ready_i = 1'b1;
        drain("qfull");
        chk("qfull count drained", int'(msg_count_o), 0);
        chk("qfull full drained", int'(fifo_full_o), 0);

        // Reset after four bytes of a 10-byte send, then a fresh 3-byte message.
        do_reset();
        xfer_cnt   = 0;
        mon_en     = 1'b1;
        tx_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back({8'h30 + 8'(i), i == 9});
        for (int i = 0; i < 10; i++) wr_byte(8'h30 + 8'(i), i == 9);
        for (int n = 0; n < 50 && xfer_cnt < 4; n++) tick();
        chk("rst mid-send reached", xfer_cnt, 4);
        mon_en = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst mid-send valid", int'(tx_valid_o), 0);
        chk("rst mid-send count", int'(msg_count_o), 0);
        chk("rst mid-send drop", int'(drop_o), 0);
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back({8'h70 + 8'(i), i == 2});
        for (int i = 0; i < 3; i++) wr_byte(8'h70 + 8'(i), i == 2);
        drain("post-rst");
        chk("post-rst count", int'(msg_count_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
